// File: rtl/rv32i_pipe_cpu.sv
// Five-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with private imem/dmem,
// full forwarding, one-cycle load-use stall and EX-stage branch resolution.
module rv32i_pipe_cpu #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] dbg_pc
);

    localparam int unsigned IW = $clog2(IMEM_WORDS);
    localparam int unsigned DW = $clog2(DMEM_BYTES);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] result;
    } mem_wb_t;

    logic [31:0] imem [0:IMEM_WORDS-1];
    logic [7:0]  dmem [0:DMEM_BYTES-1];
    logic [31:0] regs [0:31];

    logic [31:0] fetch_pc;
    if_id_t      if_id;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    assign dbg_pc = fetch_pc;

    // ID: register read, write-first against the WB port
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_rs1_val, id_rs2_val;
    assign id_rs1 = if_id.instr[19:15];
    assign id_rs2 = if_id.instr[24:20];

    always_comb begin
        id_rs1_val = '0;
        id_rs2_val = '0;
        if (id_rs1 != 5'd0)
            id_rs1_val = (mem_wb.reg_write && mem_wb.rd == id_rs1) ? mem_wb.result : regs[id_rs1];
        if (id_rs2 != 5'd0)
            id_rs2_val = (mem_wb.reg_write && mem_wb.rd == id_rs2) ? mem_wb.result : regs[id_rs2];
    end

    // MEM: little-endian word access, byte indices wrap at the array depth
    logic [DW-1:0] byte_addr [4];
    logic [31:0]   load_data, mem_result;

    always_comb begin
        for (int k = 0; k < 4; k++)
            byte_addr[k] = ex_mem.result[DW-1:0] + DW'(k);
    end

    assign load_data  = {dmem[byte_addr[3]], dmem[byte_addr[2]], dmem[byte_addr[1]], dmem[byte_addr[0]]};
    assign mem_result = ex_mem.mem_read ? load_data : ex_mem.result;

    // EX: decode, forwarding, ALU and branch resolution
    logic [6:0]  ex_op;
    logic [2:0]  ex_f3;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_a, op_b;

    assign ex_op  = id_ex.instr[6:0];
    assign ex_f3  = id_ex.instr[14:12];
    assign ex_rd  = id_ex.instr[11:7];
    assign ex_rs1 = id_ex.instr[19:15];
    assign ex_rs2 = id_ex.instr[24:20];
    assign imm_i  = {{20{id_ex.instr[31]}}, id_ex.instr[31:20]};
    assign imm_s  = {{20{id_ex.instr[31]}}, id_ex.instr[31:25], id_ex.instr[11:7]};
    assign imm_b  = {{19{id_ex.instr[31]}}, id_ex.instr[31], id_ex.instr[7],
                     id_ex.instr[30:25], id_ex.instr[11:8], 1'b0};
    assign imm_u  = {id_ex.instr[31:12], 12'b0};
    assign imm_j  = {{11{id_ex.instr[31]}}, id_ex.instr[31], id_ex.instr[19:12],
                     id_ex.instr[20], id_ex.instr[30:21], 1'b0};

    always_comb begin
        op_a = id_ex.rs1_val;
        op_b = id_ex.rs2_val;
        if (ex_mem.reg_write && ex_mem.rd == ex_rs1)      op_a = mem_result;
        else if (mem_wb.reg_write && mem_wb.rd == ex_rs1) op_a = mem_wb.result;
        if (ex_mem.reg_write && ex_mem.rd == ex_rs2)      op_b = mem_result;
        else if (mem_wb.reg_write && mem_wb.rd == ex_rs2) op_b = mem_wb.result;
    end

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    logic        ex_rw, ex_mr, ex_mw, ex_taken, br_cond;
    logic [31:0] ex_res, ex_target;

    always_comb begin
        case (ex_f3)
            3'b000:  br_cond = op_a == op_b;
            3'b001:  br_cond = op_a != op_b;
            3'b100:  br_cond = $signed(op_a) < $signed(op_b);
            3'b101:  br_cond = $signed(op_a) >= $signed(op_b);
            3'b110:  br_cond = op_a < op_b;
            3'b111:  br_cond = op_a >= op_b;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        ex_res    = '0;
        ex_rw     = 1'b0;
        ex_mr     = 1'b0;
        ex_mw     = 1'b0;
        ex_taken  = 1'b0;
        ex_target = '0;
        if (id_ex.valid) begin
            case (ex_op)
                OP_LUI:   begin ex_res = imm_u; ex_rw = 1'b1; end
                OP_AUIPC: begin ex_res = id_ex.ipc + imm_u; ex_rw = 1'b1; end
                OP_JAL: begin
                    ex_res = id_ex.ipc + 32'd4; ex_rw = 1'b1;
                    ex_taken = 1'b1; ex_target = id_ex.ipc + imm_j;
                end
                OP_JALR: begin
                    ex_res = id_ex.ipc + 32'd4; ex_rw = 1'b1;
                    ex_taken = 1'b1; ex_target = (op_a + imm_i) & ~32'd1;
                end
                OP_BRANCH: begin
                    ex_taken = br_cond; ex_target = id_ex.ipc + imm_b;
                end
                OP_LOAD:  if (ex_f3 == 3'b010) begin ex_res = op_a + imm_i; ex_rw = 1'b1; ex_mr = 1'b1; end
                OP_STORE: if (ex_f3 == 3'b010) begin ex_res = op_a + imm_s; ex_mw = 1'b1; end
                OP_IMM:   begin ex_res = alu(ex_f3, ex_f3 == 3'd5 && id_ex.instr[30], op_a, imm_i); ex_rw = 1'b1; end
                OP_REG:   begin ex_res = alu(ex_f3, id_ex.instr[30], op_a, op_b); ex_rw = 1'b1; end
                default:  ;
            endcase
        end
    end

    // Load-use: hold IF/ID and PC one cycle while a bubble enters EX
    logic stall;
    assign stall = ex_mr && ex_rd != 5'd0 && if_id.valid && (ex_rd == id_rs1 || ex_rd == id_rs2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            if_id    <= '0;
            id_ex    <= '0;
            ex_mem   <= '0;
            mem_wb   <= '0;
        end else begin
            if (ex_taken) begin
                fetch_pc <= ex_target;
                if_id    <= '0;
                id_ex    <= '0;
            end else if (stall) begin
                id_ex <= '0;
            end else begin
                fetch_pc <= fetch_pc + 32'd4;
                if_id    <= '{valid: 1'b1, ipc: fetch_pc, instr: imem[fetch_pc[IW+1:2]]};
                id_ex    <= '{valid: if_id.valid, ipc: if_id.ipc, instr: if_id.instr,
                              rs1_val: id_rs1_val, rs2_val: id_rs2_val};
            end
            ex_mem <= '{reg_write: ex_rw && ex_rd != 5'd0, mem_read: ex_mr, mem_write: ex_mw,
                        rd: ex_rd, result: ex_res, store_data: op_b};
            mem_wb <= '{reg_write: ex_mem.reg_write, rd: ex_mem.rd, result: mem_result};
        end
    end

    // Architectural storage is never reset so preloaded contents survive
    always_ff @(posedge clk) begin
        if (mem_wb.reg_write)
            regs[mem_wb.rd] <= mem_wb.result;
        if (ex_mem.mem_write)
            for (int k = 0; k < 4; k++)
                dmem[byte_addr[k]] <= ex_mem.store_data[8*k +: 8];
    end

endmodule

// File: tb/tb_rv32i_pipe_cpu.sv
// Bench for rv32i_pipe_cpu: directed pipeline scenarios plus random programs
// checked against an instruction-level reference interpreter.
module tb_rv32i_pipe_cpu;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JLOOP = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dbg_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [0:255];
    logic [31:0] pc_trace [0:63];

    logic [31:0] m_imem [0:255];
    logic [31:0] m_regs [0:31];
    logic [7:0]  m_dmem [0:1023];

    rv32i_pipe_cpu dut (.clk(clk), .reset(reset), .dbg_pc(dbg_pc));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
    endfunction

    // Reference interpreter: one architectural instruction per step
    function automatic logic [31:0] model_alu(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic model_run();
        logic [31:0] pc, ins, a, b, res, addr, npc, ii, is, ib, iu, ij;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wr, take;
        pc = 32'd0;
        for (int s = 0; s < 1000; s++) begin
            ins = m_imem[pc[9:2]];
            if (ins == JLOOP) break;
            rd = ins[11:7]; f3 = ins[14:12];
            a = m_regs[ins[19:15]]; b = m_regs[ins[24:20]];
            ii = {{20{ins[31]}}, ins[31:20]};
            is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            iu = {ins[31:12], 12'b0};
            ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            npc = pc + 32'd4; wr = 1'b0; res = 32'd0;
            case (ins[6:0])
                7'b0110111: begin res = iu; wr = 1'b1; end
                7'b0010111: begin res = pc + iu; wr = 1'b1; end
                7'b1101111: begin res = pc + 32'd4; wr = 1'b1; npc = pc + ij; end
                7'b1100111: begin res = pc + 32'd4; wr = 1'b1; npc = (a + ii) & ~32'd1; end
                7'b1100011: begin
                    case (f3)
                        3'b000: take = (a == b);
                        3'b001: take = (a != b);
                        3'b100: take = ($signed(a) < $signed(b));
                        3'b101: take = ($signed(a) >= $signed(b));
                        3'b110: take = (a < b);
                        3'b111: take = (a >= b);
                        default: take = 1'b0;
                    endcase
                    if (take) npc = pc + ib;
                end
                7'b0000011: if (f3 == 3'b010) begin
                    addr = a + ii;
                    for (int k = 0; k < 4; k++)
                        res[8*k +: 8] = m_dmem[int'((addr + 32'(k)) & 32'h3FF)];
                    wr = 1'b1;
                end
                7'b0100011: if (f3 == 3'b010) begin
                    addr = a + is;
                    for (int k = 0; k < 4; k++)
                        m_dmem[int'((addr + 32'(k)) & 32'h3FF)] = b[8*k +: 8];
                end
                7'b0010011: begin res = model_alu(f3, f3 == 3'd5 && ins[30], a, ii); wr = 1'b1; end
                7'b0110011: begin res = model_alu(f3, ins[30], a, b); wr = 1'b1; end
                default: ;
            endcase
            if (wr && rd != 5'd0) m_regs[rd] = res;
            pc = npc;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = NOP;
    endtask

    // Enter reset for two cycles, load program, clear regs and dmem
    task automatic start();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
        for (int i = 0; i < 32; i++) dut.regs[i] = 32'd0;
        for (int i = 0; i < 1024; i++) dut.dmem[i] = 8'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic go(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        pc_trace[0] = dbg_pc;
        for (int k = 1; k < cycles; k++) begin
            @(negedge clk);
            if (k < 64) pc_trace[k] = dbg_pc;
        end
    endtask

    task automatic test_reset();
        clear_prog();
        start();
        n_checks++;
        if (dbg_pc !== 32'd0) begin
            n_fail++; $display("FAIL reset_pc: got %h want 0", dbg_pc);
        end
        go(8);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (pc_trace[k] !== 32'(4 * k)) begin
                n_fail++; $display("FAIL fetch_seq[%0d]: got %h want %h", k, pc_trace[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_program();
        logic [31:0] exp_r [12] = '{0, 5, 3, 8, 8, 0, 7, 36, 0, 0, 0, 0};
        logic [7:0]  exp_m [4]  = '{8, 0, 0, 0};
        clear_prog();
        prog[0]  = addi(1, 0, 5);
        prog[1]  = addi(2, 0, 3);
        prog[2]  = enc_r(7'd0, 2, 1, 3'd0, 3);
        prog[3]  = enc_s(3, 0, 12'd0);
        prog[4]  = enc_i(7'b0000011, 3'b010, 4, 0, 12'd0);
        prog[5]  = enc_b(3'b000, 4, 3, 13'd8);
        prog[6]  = addi(5, 0, 1);
        prog[7]  = addi(6, 0, 7);
        prog[8]  = enc_j(7, 21'd16);
        prog[9]  = addi(8, 0, 9);
        prog[10] = addi(9, 0, 10);
        prog[11] = enc_r(7'd0, 1, 6, 3'd0, 10);
        start();
        go(200);
        for (int r = 1; r < 12; r++) begin
            n_checks++;
            if (dut.regs[r] !== exp_r[r]) begin
                n_fail++; $display("FAIL program_x%0d: got %h want %h", r, dut.regs[r], exp_r[r]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dut.dmem[i] !== exp_m[i]) begin
                n_fail++; $display("FAIL program_dmem[%0d]: got %h want %h", i, dut.dmem[i], exp_m[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_prog();
        prog[0] = addi(1, 0, 1);
        for (int i = 1; i <= 4; i++) prog[i] = enc_r(7'd0, 1, 1, 3'd0, 1);
        start();
        go(20);
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (pc_trace[k] !== 32'(4 * k)) begin
                n_fail++; $display("FAIL chain_no_stall[%0d]: got %h want %h", k, pc_trace[k], 32'(4 * k));
            end
        end
        n_checks++;
        if (dut.regs[1] !== 32'd16) begin
            n_fail++; $display("FAIL chain_x1: got %h want 16", dut.regs[1]);
        end
    endtask

    task automatic test_load_use();
        int repeats;
        clear_prog();
        prog[0] = enc_i(7'b0000011, 3'b010, 2, 0, 12'd0);
        prog[1] = enc_r(7'd0, 2, 2, 3'd0, 3);
        start();
        dut.dmem[0] = 8'd21;
        go(20);
        repeats = 0;
        for (int k = 1; k < 16; k++) if (pc_trace[k] == pc_trace[k-1]) repeats++;
        n_checks++;
        if (repeats != 1) begin
            n_fail++; $display("FAIL load_use_stalls: got %0d want 1", repeats);
        end
        n_checks++;
        if (pc_trace[3] !== 32'd8) begin
            n_fail++; $display("FAIL load_use_hold_pc: got %h want 8", pc_trace[3]);
        end
        n_checks++;
        if (dut.regs[3] !== 32'd42) begin
            n_fail++; $display("FAIL load_use_x3: got %0d want 42", dut.regs[3]);
        end
    endtask

    task automatic test_branch_jalr();
        logic [31:0] exp_t [11] = '{0, 4, 8, 12, 16, 20, 20, 24, 28, 64, 68};
        logic [31:0] sav7, sav8;
        clear_prog();
        prog[0]  = addi(5, 0, 12'h041);
        prog[1]  = addi(6, 0, 1);
        prog[2]  = enc_b(3'b001, 6, 6, 13'd8);
        prog[3]  = enc_b(3'b100, 0, 6, 13'd8);
        prog[4]  = addi(7, 0, 99);
        prog[5]  = enc_i(7'b1100111, 3'b000, 1, 5, 12'd0);
        prog[6]  = addi(8, 0, 55);
        prog[16] = addi(9, 0, 3);
        start();
        sav7 = 32'hA5A5_0000 | 32'($urandom_range(0, 65535));
        sav8 = 32'h5A5A_0000 | 32'($urandom_range(0, 65535));
        dut.regs[7] = sav7;
        dut.regs[8] = sav8;
        go(30);
        for (int k = 0; k < 11; k++) begin
            n_checks++;
            if (pc_trace[k] !== exp_t[k]) begin
                n_fail++; $display("FAIL branch_trace[%0d]: got %h want %h", k, pc_trace[k], exp_t[k]);
            end
        end
        n_checks++;
        if (dut.regs[1] !== 32'd24) begin
            n_fail++; $display("FAIL jalr_link: got %h want 24", dut.regs[1]);
        end
        n_checks++;
        if (dut.regs[7] !== sav7) begin
            n_fail++; $display("FAIL skipped_x7: got %h want %h", dut.regs[7], sav7);
        end
        n_checks++;
        if (dut.regs[8] !== sav8) begin
            n_fail++; $display("FAIL flushed_x8: got %h want %h", dut.regs[8], sav8);
        end
        n_checks++;
        if (dut.regs[9] !== 32'd3) begin
            n_fail++; $display("FAIL jalr_target_x9: got %h want 3", dut.regs[9]);
        end
    endtask

    task automatic test_x0_and_reset();
        logic [31:0] snap10;
        logic [7:0]  snapm [4];
        clear_prog();
        prog[0] = addi(1, 0, 5);
        prog[1] = addi(0, 0, 5);
        prog[2] = enc_r(7'd0, 0, 0, 3'd0, 2);
        prog[3] = enc_r(7'd0, 0, 1, 3'd0, 3);
        for (int i = 4; i < 120; i++)
            prog[i] = (i % 2 == 0) ? addi(10, 10, 1) : enc_s(10, 0, 12'd4);
        start();
        go(20);
        n_checks++;
        if (dut.regs[0] !== 32'd0) begin
            n_fail++; $display("FAIL x0_reg: got %h want 0", dut.regs[0]);
        end
        n_checks++;
        if (dut.regs[2] !== 32'd0) begin
            n_fail++; $display("FAIL x0_forward: got %h want 0", dut.regs[2]);
        end
        n_checks++;
        if (dut.regs[3] !== 32'd5) begin
            n_fail++; $display("FAIL x0_operand: got %h want 5", dut.regs[3]);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (dbg_pc !== 32'd0) begin
            n_fail++; $display("FAIL midrun_reset_pc: got %h want 0", dbg_pc);
        end
        snap10 = dut.regs[10];
        for (int i = 0; i < 4; i++) snapm[i] = dut.dmem[4 + i];
        repeat (5) @(negedge clk);
        n_checks++;
        if (dut.regs[10] !== snap10) begin
            n_fail++; $display("FAIL reset_blocks_regwrite: got %h want %h", dut.regs[10], snap10);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dut.dmem[4 + i] !== snapm[i]) begin
                n_fail++; $display("FAIL reset_blocks_store[%0d]: got %h want %h", 4 + i, dut.dmem[4 + i], snapm[i]);
            end
        end
        n_checks++;
        if (dbg_pc !== 32'd0) begin
            n_fail++; $display("FAIL reset_hold_pc: got %h want 0", dbg_pc);
        end
    endtask

    function automatic logic [31:0] rand_instr(input int idx);
        logic [2:0]  bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          r;
        r   = $urandom_range(0, 99);
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        if (r < 30) begin
            if (f3 == 3'd1) imm[11:5] = 7'd0;
            if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            return enc_i(7'b0010011, f3, rd, rs1, imm);
        end else if (r < 55) begin
            return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                         rs2, rs1, f3, rd);
        end else if (r < 63) begin
            return {20'($urandom), rd, $urandom_range(0, 1) ? 7'b0110111 : 7'b0010111};
        end else if (r < 73) begin
            return enc_i(7'b0000011, 3'b010, rd, rs1, 12'($urandom_range(0, 63)));
        end else if (r < 83) begin
            return enc_s(rs2, rs1, 12'($urandom_range(0, 63)));
        end else if (r < 93) begin
            if (idx + 3 > 40) return NOP;
            return enc_b(bf3[$urandom_range(0, 5)], rs1, rs2, $urandom_range(0, 1) ? 13'd8 : 13'd12);
        end else if (r < 97) begin
            if (idx + 2 > 40) return NOP;
            return enc_j(rd, 21'd8);
        end
        return {25'($urandom), 7'b0001011};
    endfunction

    task automatic test_random();
        int bad, first;
        for (int it = 0; it < 6; it++) begin
            clear_prog();
            for (int i = 0; i < 40; i++) prog[i] = rand_instr(i);
            prog[40] = JLOOP;
            start();
            for (int i = 0; i < 256; i++) m_imem[i] = prog[i];
            m_regs[0] = 32'd0;
            for (int i = 1; i < 32; i++) begin
                m_regs[i] = $urandom;
                dut.regs[i] = m_regs[i];
            end
            for (int i = 0; i < 1024; i++) begin
                m_dmem[i] = 8'($urandom);
                dut.dmem[i] = m_dmem[i];
            end
            model_run();
            go(200);
            for (int r = 1; r < 32; r++) begin
                n_checks++;
                if (dut.regs[r] !== m_regs[r]) begin
                    n_fail++; $display("FAIL random%0d_x%0d: got %h want %h", it, r, dut.regs[r], m_regs[r]);
                end
            end
            bad = 0; first = -1;
            for (int i = 0; i < 1024; i++)
                if (dut.dmem[i] !== m_dmem[i]) begin
                    bad++;
                    if (first < 0) first = i;
                end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL random%0d_dmem: %0d bytes differ, first at %0d got %h want %h",
                         it, bad, first, dut.dmem[first], m_dmem[first]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_back_to_back();
        test_load_use();
        test_branch_jalr();
        test_x0_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
